// File: rtl/mem_io_responder_pkg.sv
// Shared address map and decode helper for the memory-bus responder.
package mem_io_responder_pkg;

  localparam int ADDR_WIDTH = 18;

  localparam logic [17:0] IO_DATA_ADDR = 18'h30000;
  localparam logic [17:0] IO_HALT_ADDR = 18'h30004;
  localparam logic [1:0]  IO_SEL_BITS  = 2'b11;

  typedef enum logic [1:0] {
    ACC_RAM,
    ACC_IO_DATA,
    ACC_IO_HALT,
    ACC_IO_OTHER
  } acc_kind_e;

  function automatic acc_kind_e decode_addr(input logic [17:0] a);
    if (a[17:16] != IO_SEL_BITS) return ACC_RAM;
    if (a == IO_DATA_ADDR)       return ACC_IO_DATA;
    if (a == IO_HALT_ADDR)       return ACC_IO_HALT;
    return ACC_IO_OTHER;
  endfunction

endpackage

// File: rtl/mem_io_responder_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mem_io_responder.sv
// Target side of the byte-serial memory bus: byte RAM with 1-cycle read
// latency plus a UART TX/RX FIFO and sticky halt flag in the IO window.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int    RAM_AW      = 17,
  parameter int    TX_DEPTH    = 16,
  parameter int    RX_DEPTH    = 16,
  parameter int    FULL_MARGIN = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst_in_n,
  input  logic                  rdy_in,
  input  logic [ADDR_WIDTH-1:0] mem_a,
  input  logic                  mem_wr,
  input  logic [7:0]            mem_wdata,
  output logic [7:0]            mem_rdata,
  output logic                  io_buffer_full,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  halt,
  output logic                  tx_overflow
);

  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  logic [7:0] ram [2**RAM_AW];
  logic [7:0] ram_rd_q;

  logic [7:0] io_rd_q, io_rd_d;
  logic       src_ram_q, src_ram_d;
  logic       halt_q, halt_d;
  logic       tx_overflow_q, tx_overflow_d;
  logic       io_buffer_full_q, io_buffer_full_d;

  acc_kind_e      acc;
  logic           ram_we, ram_re;
  logic           tx_push_req, tx_accept, tx_pop;
  logic           tx_empty, tx_full;
  logic [TCW-1:0] tx_count, tx_count_next;
  logic           rx_pop_req, rx_push;
  logic           rx_empty, rx_full;
  logic [RCW-1:0] rx_count;
  logic [7:0]     rx_dout;

  assign acc      = decode_addr(mem_a[17:0]);
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;

  always_comb begin
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    tx_push_req   = 1'b0;
    rx_pop_req    = 1'b0;
    io_rd_d       = io_rd_q;
    src_ram_d     = src_ram_q;
    halt_d        = halt_q;
    tx_overflow_d = tx_overflow_q;

    if (rdy_in) begin
      unique case (acc)
        ACC_RAM: begin
          if (mem_wr) begin
            ram_we = 1'b1;
          end else begin
            ram_re    = 1'b1;
            src_ram_d = 1'b1;
          end
        end
        ACC_IO_DATA: begin
          if (mem_wr) begin
            tx_push_req = 1'b1;
          end else begin
            rx_pop_req = !rx_empty;
            io_rd_d    = rx_empty ? 8'h00 : rx_dout;
            src_ram_d  = 1'b0;
          end
        end
        ACC_IO_HALT: begin
          if (mem_wr) begin
            halt_d = 1'b1;
          end else begin
            io_rd_d   = {7'b0, (rx_count != '0)};
            src_ram_d = 1'b0;
          end
        end
        default: begin
          if (!mem_wr) begin
            io_rd_d   = 8'h00;
            src_ram_d = 1'b0;
          end
        end
      endcase
    end

    // A full FIFO still takes the byte when the host drains one this cycle.
    tx_accept = tx_push_req && (!tx_full || tx_pop);
    if (tx_push_req && !tx_accept) tx_overflow_d = 1'b1;

    tx_count_next    = tx_count + TCW'(tx_accept) - TCW'(tx_pop);
    io_buffer_full_d = (tx_count_next >= TCW'(TX_DEPTH - FULL_MARGIN));
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[mem_a[RAM_AW-1:0]] <= mem_wdata;
    if (ram_re) ram_rd_q <= ram[mem_a[RAM_AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      io_rd_q          <= 8'h00;
      src_ram_q        <= 1'b0;
      halt_q           <= 1'b0;
      tx_overflow_q    <= 1'b0;
      io_buffer_full_q <= 1'b0;
    end else begin
      io_rd_q          <= io_rd_d;
      src_ram_q        <= src_ram_d;
      halt_q           <= halt_d;
      tx_overflow_q    <= tx_overflow_d;
      io_buffer_full_q <= io_buffer_full_d;
    end
  end

  // RAM data stays in the unreset block-RAM register; the select flop picks it.
  assign mem_rdata      = src_ram_q ? ram_rd_q : io_rd_q;
  assign halt           = halt_q;
  assign tx_overflow    = tx_overflow_q;
  assign io_buffer_full = io_buffer_full_q;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_in_n),
    .push  (tx_push_req),
    .pop   (tx_pop),
    .din   (mem_wdata),
    .dout  (tx_data),
    .empty (tx_empty),
    .full  (tx_full),
    .count (tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_in_n),
    .push  (rx_push),
    .pop   (rx_pop_req),
    .din   (rx_data),
    .dout  (rx_dout),
    .empty (rx_empty),
    .full  (rx_full),
    .count (rx_count)
  );

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, TX/RX FIFOs, halt, freeze, reset.
module tb_mem_io_responder;
  import mem_io_responder_pkg::*;

  logic                  clk;
  logic                  rst_in_n;
  logic                  rdy_in;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic [7:0]            mem_wdata;
  logic [7:0]            mem_rdata;
  logic                  io_buffer_full;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  halt;
  logic                  tx_overflow;

  int n_cmp = 0;
  int n_err = 0;

  mem_io_responder dut (
    .clk            (clk),
    .rst_in_n       (rst_in_n),
    .rdy_in         (rdy_in),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .halt           (halt),
    .tx_overflow    (tx_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    rst_in_n  = 1'b0;
    rdy_in    = 1'b1;
    mem_a     = '0;
    mem_wr    = 1'b0;
    mem_wdata = 8'h00;
    tx_ready  = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;

    #3;
    check("rst_rdata", mem_rdata, 8'h00);
    check("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    check("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    check("rst_buf_full", {7'b0, io_buffer_full}, 8'h00);
    check("rst_halt", {7'b0, halt}, 8'h00);
    check("rst_overflow", {7'b0, tx_overflow}, 8'h00);
    tick();
    tick();
    @(negedge clk);
    rst_in_n = 1'b1;

    // RAM write then read: data one cycle after the read address
    mem_a = 18'h00010; mem_wr = 1'b1; mem_wdata = 8'hA5;
    tick();
    mem_wr = 1'b0;
    tick();
    check("ram_rd_10", mem_rdata, 8'hA5);

    // Fill TX to 16, then write 0x5A while the host pops: accepted
    mem_a = IO_DATA_ADDR; mem_wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem_wdata = 8'(i);
      tick();
    end
    check("fill16_full", {7'b0, io_buffer_full}, 8'h01);
    tx_ready = 1'b1; mem_wdata = 8'h5A;
    tick();
    check("popfull_ovf", {7'b0, tx_overflow}, 8'h00);
    check("popfull_bfull", {7'b0, io_buffer_full}, 8'h01);
    mem_wr = 1'b0; mem_a = '0;
    for (int i = 1; i < 16; i++) begin
      check("popfull_drain", tx_data, 8'(i));
      tick();
    end
    check("popfull_last", tx_data, 8'h5A);
    tick();
    check("popfull_empty", {7'b0, tx_valid}, 8'h00);
    check("popfull_bclr", {7'b0, io_buffer_full}, 8'h00);
    tx_ready = 1'b0;

    // Overflow: 17 writes with the host stalled
    mem_a = IO_DATA_ADDR; mem_wr = 1'b1;
    for (int i = 0; i < 17; i++) begin
      mem_wdata = 8'(i);
      tick();
      if (i == 12) check("ovf_bfull_13", {7'b0, io_buffer_full}, 8'h00);
      if (i == 13) check("ovf_bfull_14", {7'b0, io_buffer_full}, 8'h01);
      if (i == 15) check("ovf_flag_16", {7'b0, tx_overflow}, 8'h00);
    end
    check("ovf_flag_17", {7'b0, tx_overflow}, 8'h01);
    mem_wr = 1'b0; mem_a = '0; tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ovf_drain", tx_data, 8'(i));
      tick();
    end
    check("ovf_empty", {7'b0, tx_valid}, 8'h00);
    tx_ready = 1'b0;

    // RX path
    rx_valid = 1'b1; rx_data = 8'h41;
    tick();
    rx_data = 8'h42;
    tick();
    rx_valid = 1'b0;
    mem_a = IO_HALT_ADDR;
    tick();
    check("rx_status_1", mem_rdata, 8'h01);
    mem_a = IO_DATA_ADDR;
    tick();
    check("rx_pop_41", mem_rdata, 8'h41);
    tick();
    check("rx_pop_42", mem_rdata, 8'h42);
    mem_a = IO_HALT_ADDR;
    tick();
    check("rx_status_0", mem_rdata, 8'h00);
    mem_a = IO_DATA_ADDR;
    tick();
    check("rx_pop_empty", mem_rdata, 8'h00);

    // Freeze: write blocked, mem_rdata held
    mem_a = 18'h00100; mem_wr = 1'b1; mem_wdata = 8'h33;
    tick();
    mem_wr = 1'b0;
    tick();
    check("frz_pre_rd", mem_rdata, 8'h33);
    rdy_in = 1'b0; mem_wr = 1'b1; mem_wdata = 8'h77;
    tick();
    check("frz_hold_wr", mem_rdata, 8'h33);
    mem_wr = 1'b0; mem_a = 18'h00010;
    tick();
    check("frz_hold_rd", mem_rdata, 8'h33);
    rdy_in = 1'b1; mem_a = 18'h00100;
    tick();
    check("frz_ram_old", mem_rdata, 8'h33);

    // Halt, then asynchronous reset mid-cycle
    mem_a = IO_HALT_ADDR; mem_wr = 1'b1;
    tick();
    check("halt_set", {7'b0, halt}, 8'h01);
    mem_wr = 1'b0; mem_a = 18'h00010;
    #2;
    rst_in_n = 1'b0;
    #1;
    check("arst_halt", {7'b0, halt}, 8'h00);
    check("arst_ovf", {7'b0, tx_overflow}, 8'h00);
    check("arst_rdata", mem_rdata, 8'h00);
    @(negedge clk);
    rst_in_n = 1'b1;
    tick();
    check("ram_survives", mem_rdata, 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
